data_sync: RTL and testbench

DATA_SYNC -- requirements
Module: data_sync

---
 rtl/data_sync.sv | 92 +++++++++
 tb/tb_data_sync.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync.sv
// Purpose: move a source-domain data word into CLK using a synchronised level qualifier.
// Latency: the word, its strobe and DATA_VALID appear NUM_STAGES+1 edges after BUS_ENABLE is first sampled high.
// Backpressure: none toward the source; a capture while a word is unacknowledged overwrites it and sets OVERRUN.
module data_sync #(
    parameter int NUM_STAGES = 2,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    input  logic                 DATA_ACK,
    input  logic                 OVERRUN_CLR,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 DATA_VALID,
    output logic                 OVERRUN
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [NUM_STAGES-1:0] sync_ff;
    logic                  pulse_ff;
    logic                  sync_en;
    logic                  rise;
    logic                  overrun_d;

    // Only the qualifier crosses through the chain; the data bus is sampled
    // once the qualifier has settled, so it never needs its own synchroniser.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_ff  <= '0;
            pulse_ff <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[NUM_STAGES-2:0], BUS_ENABLE};
            pulse_ff <= sync_en;
        end
    end

    assign sync_en = sync_ff[NUM_STAGES-1];
    assign rise    = sync_en & ~pulse_ff;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            SYNC_BUS     <= '0;
            ENABLE_PULSE <= 1'b0;
            state_q      <= IDLE;
            OVERRUN      <= 1'b0;
        end else begin
            if (rise) begin
                SYNC_BUS <= UNSYNC_BUS;
            end
            ENABLE_PULSE <= rise;
            state_q      <= state_d;
            OVERRUN      <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        overrun_d = OVERRUN;
        if (OVERRUN_CLR) begin
            overrun_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rise) begin
                    // A fresh word replaces the held one; it is lost only if not acked now.
                    if (!DATA_ACK) begin
                        overrun_d = 1'b1;
                    end
                end else if (DATA_ACK) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign DATA_VALID = (state_q == HOLD);

endmodule

// File: tb/tb_data_sync.sv
// Bench for data_sync: directed scenarios plus a randomized asynchronous-phase run
// checked against a word queue holding what the source sent.
`timescale 1ns/1ps
module tb_data_sync;

    localparam int NS = 2;
    localparam int BW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [BW-1:0] UNSYNC_BUS = '0;
    logic          BUS_ENABLE = 1'b0;
    logic          DATA_ACK = 1'b0;
    logic          OVERRUN_CLR = 1'b0;
    logic [BW-1:0] SYNC_BUS;
    logic          ENABLE_PULSE;
    logic          DATA_VALID;
    logic          OVERRUN;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;

    data_sync #(.NUM_STAGES(NS), .BUS_WIDTH(BW)) dut (
        .CLK(CLK),
        .RST(RST),
        .UNSYNC_BUS(UNSYNC_BUS),
        .BUS_ENABLE(BUS_ENABLE),
        .DATA_ACK(DATA_ACK),
        .OVERRUN_CLR(OVERRUN_CLR),
        .SYNC_BUS(SYNC_BUS),
        .ENABLE_PULSE(ENABLE_PULSE),
        .DATA_VALID(DATA_VALID),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Raise, hold for `hold` cycles, drop, then stay low long enough to re-arm.
    task automatic send_word(input logic [BW-1:0] d, input int hold);
        UNSYNC_BUS = d;
        BUS_ENABLE = 1'b1;
        tick(hold);
        BUS_ENABLE = 1'b0;
        tick(NS + 2);
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({SYNC_BUS, ENABLE_PULSE, DATA_VALID, OVERRUN} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got bus=%h pulse=%b valid=%b ovr=%b want all 0",
                     SYNC_BUS, ENABLE_PULSE, DATA_VALID, OVERRUN);
        end
        tick(3);
        RST = 1'b1;
        tick(2);
        checks++;
        if ({ENABLE_PULSE, DATA_VALID, OVERRUN} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got pulse=%b valid=%b ovr=%b want 000",
                     ENABLE_PULSE, DATA_VALID, OVERRUN);
        end
    endtask

    task automatic test_basic;
        int pulses = 0;
        UNSYNC_BUS = 8'hA5;
        BUS_ENABLE = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            pulses += int'(ENABLE_PULSE);
            checks++;
            if (ENABLE_PULSE !== (cyc == NS + 1)) begin
                errors++;
                $display("FAIL basic_pulse_c%0d: got %b want %b", cyc, ENABLE_PULSE, cyc == NS + 1);
            end
            if (cyc == NS + 1) begin
                checks++;
                if (SYNC_BUS !== 8'hA5 || DATA_VALID !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_capture: got bus=%h valid=%b want a5 1", SYNC_BUS, DATA_VALID);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL basic_pulse_count: got %0d want 1", pulses);
        end
        BUS_ENABLE = 1'b0;
        pulses = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            pulses += int'(ENABLE_PULSE);
        end
        checks++;
        if (pulses != 0 || DATA_VALID !== 1'b1 || SYNC_BUS !== 8'hA5) begin
            errors++;
            $display("FAIL basic_fall: got pulses=%0d valid=%b bus=%h want 0 1 a5", pulses, DATA_VALID, SYNC_BUS);
        end
        DATA_ACK = 1'b1;
        tick();
        DATA_ACK = 1'b0;
        checks++;
        if (DATA_VALID !== 1'b0 || SYNC_BUS !== 8'hA5 || OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack: got valid=%b bus=%h ovr=%b want 0 a5 0", DATA_VALID, SYNC_BUS, OVERRUN);
        end
        DATA_ACK = 1'b1;
        tick();
        DATA_ACK = 1'b0;
        checks++;
        if (DATA_VALID !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: got valid=%b want 0", DATA_VALID);
        end
    endtask

    task automatic test_overrun;
        send_word(8'h11, 4);
        checks++;
        if (SYNC_BUS !== 8'h11 || DATA_VALID !== 1'b1 || OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first: got bus=%h valid=%b ovr=%b want 11 1 0", SYNC_BUS, DATA_VALID, OVERRUN);
        end
        send_word(8'h22, 4);
        checks++;
        if (SYNC_BUS !== 8'h22 || DATA_VALID !== 1'b1 || OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL ovr_second: got bus=%h valid=%b ovr=%b want 22 1 1", SYNC_BUS, DATA_VALID, OVERRUN);
        end
        tick(3);
        checks++;
        if (OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: got %b want 1", OVERRUN);
        end
        OVERRUN_CLR = 1'b1;
        tick();
        OVERRUN_CLR = 1'b0;
        checks++;
        if (OVERRUN !== 1'b0 || DATA_VALID !== 1'b1) begin
            errors++;
            $display("FAIL ovr_clear: got ovr=%b valid=%b want 0 1", OVERRUN, DATA_VALID);
        end
        // Clear coinciding with a fresh overrun: the set must win.
        UNSYNC_BUS = 8'h33;
        BUS_ENABLE = 1'b1;
        tick(NS);
        OVERRUN_CLR = 1'b1;
        tick();
        OVERRUN_CLR = 1'b0;
        checks++;
        if (ENABLE_PULSE !== 1'b1 || OVERRUN !== 1'b1 || SYNC_BUS !== 8'h33) begin
            errors++;
            $display("FAIL ovr_set_wins: got pulse=%b ovr=%b bus=%h want 1 1 33", ENABLE_PULSE, OVERRUN, SYNC_BUS);
        end
        BUS_ENABLE = 1'b0;
        tick(NS + 2);
        OVERRUN_CLR = 1'b1;
        DATA_ACK = 1'b1;
        tick();
        OVERRUN_CLR = 1'b0;
        DATA_ACK = 1'b0;
        checks++;
        if (OVERRUN !== 1'b0 || DATA_VALID !== 1'b0) begin
            errors++;
            $display("FAIL ovr_cleanup: got ovr=%b valid=%b want 0 0", OVERRUN, DATA_VALID);
        end
    endtask

    task automatic test_ack_collision;
        send_word(8'h44, 4);
        UNSYNC_BUS = 8'h55;
        BUS_ENABLE = 1'b1;
        tick(NS);
        DATA_ACK = 1'b1;
        tick();
        DATA_ACK = 1'b0;
        checks++;
        if (ENABLE_PULSE !== 1'b1 || SYNC_BUS !== 8'h55 || DATA_VALID !== 1'b1 || OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ack_collision: got pulse=%b bus=%h valid=%b ovr=%b want 1 55 1 0",
                     ENABLE_PULSE, SYNC_BUS, DATA_VALID, OVERRUN);
        end
        BUS_ENABLE = 1'b0;
        tick(NS + 2);
        DATA_ACK = 1'b1;
        tick();
        DATA_ACK = 1'b0;
        checks++;
        if (DATA_VALID !== 1'b0 || OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL ack_collision_end: got valid=%b ovr=%b want 0 0", DATA_VALID, OVERRUN);
        end
    endtask

    task automatic test_reset_in_hold;
        int pulses = 0;
        UNSYNC_BUS = 8'h5A;
        BUS_ENABLE = 1'b1;
        tick(NS + 1);
        // Pile an overrun on top so reset must clear both flags.
        BUS_ENABLE = 1'b0;
        tick(NS + 2);
        UNSYNC_BUS = 8'h6B;
        BUS_ENABLE = 1'b1;
        tick(NS + 1);
        checks++;
        if (DATA_VALID !== 1'b1 || OVERRUN !== 1'b1 || SYNC_BUS !== 8'h6B) begin
            errors++;
            $display("FAIL rst_hold_setup: got valid=%b ovr=%b bus=%h want 1 1 6b", DATA_VALID, OVERRUN, SYNC_BUS);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({SYNC_BUS, ENABLE_PULSE, DATA_VALID, OVERRUN} !== '0) begin
            errors++;
            $display("FAIL rst_async: got bus=%h pulse=%b valid=%b ovr=%b want all 0",
                     SYNC_BUS, ENABLE_PULSE, DATA_VALID, OVERRUN);
        end
        UNSYNC_BUS = 8'h3C;
        tick(2);
        RST = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            pulses += int'(ENABLE_PULSE);
            if (cyc == NS + 1) begin
                checks++;
                if (ENABLE_PULSE !== 1'b1 || SYNC_BUS !== 8'h3C || DATA_VALID !== 1'b1 || OVERRUN !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_release_capture: got pulse=%b bus=%h valid=%b ovr=%b want 1 3c 1 0",
                             ENABLE_PULSE, SYNC_BUS, DATA_VALID, OVERRUN);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL rst_release_count: got %0d want 1", pulses);
        end
        BUS_ENABLE = 1'b0;
        tick(NS + 2);
        DATA_ACK = 1'b1;
        tick();
        DATA_ACK = 1'b0;
    endtask

    task automatic test_random;
        logic [BW-1:0] exp_q[$];
        int            raise_q[$];
        int            words = 0;
        int            pulses = 0;
        bit            stim_done = 1'b0;
        fork
            begin
                for (int w = 0; w < 1000; w++) begin
                    logic [BW-1:0] d;
                    @(posedge CLK);
                    #($urandom_range(2, 9));
                    d = BW'($urandom);
                    UNSYNC_BUS = d;
                    BUS_ENABLE = 1'b1;
                    exp_q.push_back(d);
                    raise_q.push_back(cycle_cnt);
                    words++;
                    repeat ($urandom_range(NS + 1, NS + 4)) @(posedge CLK);
                    #($urandom_range(2, 9));
                    BUS_ENABLE = 1'b0;
                    repeat ($urandom_range(NS + 1, NS + 3)) @(posedge CLK);
                end
                repeat (NS + 4) @(posedge CLK);
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge CLK);
                    #1;
                    DATA_ACK = 1'b0;
                    if (ENABLE_PULSE) begin
                        pulses++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rand_extra_pulse: got pulse at cycle %0d want none pending", cycle_cnt);
                        end else begin
                            logic [BW-1:0] e;
                            int            lat;
                            e   = exp_q.pop_front();
                            lat = cycle_cnt - raise_q.pop_front();
                            if (SYNC_BUS !== e || DATA_VALID !== 1'b1 || OVERRUN !== 1'b0 ||
                                lat < NS + 1 || lat > NS + 2) begin
                                errors++;
                                $display("FAIL rand_word: got bus=%h valid=%b ovr=%b lat=%0d want %h 1 0 %0d..%0d",
                                         SYNC_BUS, DATA_VALID, OVERRUN, lat, e, NS + 1, NS + 2);
                            end
                        end
                        DATA_ACK = 1'b1;
                    end
                end
                DATA_ACK = 1'b0;
            end
        join
        tick();
        checks++;
        if (pulses != words || exp_q.size() != 0 || OVERRUN !== 1'b0 || DATA_VALID !== 1'b0) begin
            errors++;
            $display("FAIL rand_summary: got pulses=%0d words=%0d pending=%0d ovr=%b valid=%b want equal 0 0 0",
                     pulses, words, exp_q.size(), OVERRUN, DATA_VALID);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_ack_collision();
        test_reset_in_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
